serial_adder_nb: RTL
====================

Name: serial_adder_nb

Overview:
- Parametrised multi-cycle adder/subtractor and successor to the single-bit full adder cell.
- Processes a WIDTH-bit operand pair DIGIT bits per clock. A carry register chains the digits, replacing a full combinational ripple chain.
- Uses a start/busy/done handshake. Sits beside the ripple-carry adders as the area-lean arithmetic unit for datapaths that tolerate multi-cycle latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits added per clock cycle; 1 gives a pure bit-serial adder; DIGIT=WIDTH gives single-cycle operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request an operation; sampled only in IDLE or DONE.
- sub  input  1  0 = add, 1 = subtract (a - b); latched with start.
- a  input  WIDTH  operand A; latched with start.
- b  input  WIDTH  operand B; latched with start.
- c_in  input  1  carry-in for add; ignored when sub=1; latched with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- s  output  WIDTH  result; registered; held stable between completions.
- c_out  output  1  carry out of the MSB; for sub it is NOT borrow (1 = no borrow).
- ovf  output  1  two's-complement signed overflow of the operation.

Behaviour:
- N = WIDTH/DIGIT. A local cycle counter has ceil(log2(N+1)) bits.
- States: IDLE, RUN, DONE.
- Reset (rst=1 at a rising edge), in any state including mid-RUN:
  - state to IDLE, counter to 0, internal shift registers to 0.
  - busy=0, done=0, s=0, c_out=0, ovf=0.
  - An in-flight operation is discarded; no done pulse follows.
- Start acceptance, at an edge E0 in IDLE or DONE with start=1:
  - latch A into the operand register.
  - latch B' = sub ? ~b : b.
  - carry register = sub ? 1 : c_in.
  - latch the sign bits a[WIDTH-1] and B'[WIDTH-1].
  - counter = 0; state to RUN.
- RUN, one digit per edge:
  - {carry, digit} = A[DIGIT-1:0] + B'[DIGIT-1:0] + carry.
  - Shift A and B' right by DIGIT.
  - Shift the digit into the top of the partial-sum register.
  - Increment the counter.
- Completion at edge E0+N (after the N-th digit):
  - s = partial sum; c_out = final carry.
  - ovf = (signA == signB') && (s[WIDTH-1] != signA).
  - state to DONE; done=1.
- Timing: busy=1 during cycles E0+1..E0+N. done=1 for exactly the cycle after E0+N. Latency from start edge to done is N+1 edges.
- DONE lasts one cycle, then returns to IDLE. If start=1 in DONE, the new operation is accepted in that same edge (back-to-back), done drops, and busy rises.
- start=1 while in RUN is ignored; operands and sub may change freely during RUN without effect.
- s, c_out and ovf change only at completion or reset. They hold their last values through IDLE and through the next RUN.
- Wrap-around: the sum is modulo 2^WIDTH. The carry out of the top digit goes only to c_out.
- DIGIT=WIDTH (N=1): RUN lasts one cycle and done follows the start edge by 2 edges. The design must still be correct in this case.

Test Plan:
- Reset then idle: WIDTH=16, DIGIT=4. Hold rst 2 cycles, then start=0 for 10 cycles -> busy=0, done=0, s=0x0000, c_out=0, ovf=0 throughout.
- Add with wrap: a=0xFFFF, b=0x0001, c_in=0, sub=0, one-cycle start -> busy high exactly 4 cycles, then done pulse with s=0x0000, c_out=1, ovf=0. Also a=0x7FFF, b=0x0001 -> s=0x8000, c_out=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, sub=1, c_in=1 (ignored) -> s=0xFFFE, c_out=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, c_out=1, ovf=1.
- Handshake: pulse start and change a/b/start every cycle during RUN -> result matches the operands latched at the start edge. Assert start in the DONE cycle -> second result follows after another 5 edges with no idle gap. s stays stable between done pulses.
- Reset mid-operation: start a=0x1234, b=0x1111, then assert rst at the 2nd RUN cycle -> no done pulse and all outputs 0. A fresh start completes with s=0x2345.
- Parameter sweep: DIGIT in {1, 2, 4, 16} with WIDTH=16, plus 1000 random operand/sub/c_in triples per configuration -> s, c_out, ovf match a reference model. done arrives WIDTH/DIGIT+1 edges after the start edge.

Source files
------------

// File: rtl/serial_adder_nb.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, start/busy/done.
// Carry chains between digits through a register instead of a ripple.
module serial_adder_nb #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] psum_nxt;
  logic [DIGIT:0]   dsum;
  logic             carry;
  logic             sign_a;
  logic             sign_b;
  logic             accept;
  logic             last;

  // Subtract is a + ~b + 1: invert B here, force carry-in on accept.
  assign b_in   = sub ? ~b : b;
  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (cnt == CW'(N - 1));

  assign dsum = {1'b0, a_q[DIGIT-1:0]}
              + {1'b0, b_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry};

  // New digit enters at the top; after N digits the LSB digit is at bit 0.
  assign psum_nxt = (psum >> DIGIT)
                  | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: DONE is a single cycle and may chain straight into RUN.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, per-digit shift/add, and result capture on the last digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      psum   <= '0;
      carry  <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      s      <= '0;
      c_out  <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b_in;
      carry  <= sub ? 1'b1 : c_in;
      sign_a <= a[WIDTH-1];
      sign_b <= b_in[WIDTH-1];
      cnt    <= '0;
    end else if (state == RUN) begin
      a_q   <= a_q >> DIGIT;
      b_q   <= b_q >> DIGIT;
      carry <= dsum[DIGIT];
      psum  <= psum_nxt;
      cnt   <= cnt + 1'b1;
      if (last) begin
        s     <= psum_nxt;
        c_out <= dsum[DIGIT];
        ovf   <= (sign_a == sign_b) &&
                 (psum_nxt[WIDTH-1] != sign_a);
      end
    end
  end

endmodule
